alu_issue_decode: RTL

- Front end that feeds the integer ALU. Decodes RV32I register/immediate ALU instructions (OP, OP-IMM, LUI, AUIPC) into an ALU operation code, operand-source selects, an immediate and register indices.
- Registered, valid/ready stage with a 2-entry skid buffer. Sits between fetch and the register-read/ALU stage.
- Instructions it does not decode leave the stage flagged illegal so the downstream trap logic can act on them.

---
 rtl/alu_issue_decode_pkg.sv | 74 +++++++
 rtl/alu_issue_decode_if.sv | 42 ++++
 rtl/alu_issue_decode_decoder.sv | 92 +++++++++
 rtl/alu_issue_decode.sv | 108 ++++++++++
 4 files changed

// File: rtl/alu_issue_decode_pkg.sv
// Shared types for the ALU issue/decode front end and the ALU behind it.
// Contents:
//   - alu_op_t     : 4-bit ALU operation code (the ALU decodes the same values)
//   - OPC_*        : RV32I major opcodes handled by this stage
//   - op1_sel_t    : operand-1 source (rs1, pc, zero)
//   - op2_sel_t    : operand-2 source (rs2, imm)
//   - decoded_t    : one decoded instruction as held in the issue buffer
//   - regAluOp     : funct3 -> operation for the plain (funct7 == 0) forms
package alu_pkg;

    localparam int XLEN = 32;
    localparam int PC_W = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_SUBI = 4'd10
    } alu_op_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        OP1_RS1  = 2'd0,
        OP1_PC   = 2'd1,
        OP1_ZERO = 2'd2
    } op1_sel_t;

    typedef enum logic {
        OP2_RS2 = 1'b0,
        OP2_IMM = 1'b1
    } op2_sel_t;

    typedef struct packed {
        alu_op_t         alu_op;
        op1_sel_t        op1_sel;
        op2_sel_t        op2_sel;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            rd_we;
        logic            illegal;
        logic [PC_W-1:0] pc;
    } decoded_t;

    // Operation selected by funct3 when funct7 is all zeros. OP-IMM reuses
    // this table too, since 000 there always means ADD.
    function automatic alu_op_t regAluOp(input logic [2:0] funct3);
        alu_op_t op;
        case (funct3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_issue_decode_if.sv
// Fetch-side and ALU-side handshake bundle of the issue/decode stage.
//   in_*  : instruction from fetch (valid/ready, raw word, pc)
//   out_* : decoded entry towards register read / ALU (valid/ready + fields)
// Modports:
//   master : the environment (drives in_valid/in_instr/in_pc/out_ready)
//   slave  : the decode stage
interface alu_issue_decode_if #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) ();

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_alu_op;
    logic [1:0]      out_op1_sel;
    logic            out_op2_sel;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic            out_rd_we;
    logic            out_illegal;
    logic [PC_W-1:0] out_pc;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_alu_op, out_op1_sel, out_op2_sel,
               out_imm, out_rs1, out_rs2, out_rd, out_rd_we, out_illegal, out_pc
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_alu_op, out_op1_sel, out_op2_sel,
               out_imm, out_rs1, out_rs2, out_rd, out_rd_we, out_illegal, out_pc
    );

endinterface

// File: rtl/alu_issue_decode_decoder.sv
// Purely combinational RV32I ALU-instruction decoder.
// Ports:
//   instr_i : raw 32-bit instruction word
//   dec_o   : decoded fields; the pc field is left zero and filled by the caller
module alu_instr_decoder
    import alu_pkg::*;
(
    input  logic [31:0] instr_i,
    output decoded_t    dec_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] shamt;
    logic       legal;
    decoded_t   dec;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign shamt  = instr_i[24:20];

    // Opcodes outside the four ALU classes never match, which also rejects
    // any word whose low two bits are not 11. Anything rejected is reduced
    // to a harmless ADD with no register write so only the trap flag matters.
    always_comb begin
        dec     = '0;
        legal   = 1'b0;
        dec.rs1 = instr_i[19:15];
        dec.rs2 = instr_i[24:20];
        dec.rd  = instr_i[11:7];

        case (opcode)
            OPC_OP: begin
                if (funct7 == 7'b0000000) begin
                    legal      = 1'b1;
                    dec.alu_op = regAluOp(funct3);
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    legal      = 1'b1;
                    dec.alu_op = ALU_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    legal      = 1'b1;
                    dec.alu_op = ALU_SRA;
                end
            end
            OPC_OP_IMM: begin
                dec.op2_sel = OP2_IMM;
                dec.rs2     = '0;
                dec.imm     = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
                case (funct3)
                    3'b001: begin
                        legal      = (funct7 == 7'b0000000);
                        dec.alu_op = ALU_SLL;
                        dec.imm    = {{(XLEN-5){1'b0}}, shamt};
                    end
                    3'b101: begin
                        legal      = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                        dec.alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                        dec.imm    = {{(XLEN-5){1'b0}}, shamt};
                    end
                    default: begin
                        legal      = 1'b1;
                        dec.alu_op = regAluOp(funct3);
                    end
                endcase
            end
            OPC_LUI, OPC_AUIPC: begin
                legal       = 1'b1;
                dec.alu_op  = ALU_ADD;
                dec.op1_sel = (opcode == OPC_LUI) ? OP1_ZERO : OP1_PC;
                dec.op2_sel = OP2_IMM;
                dec.rs2     = '0;
                dec.imm     = XLEN'({instr_i[31:12], 12'b0});
            end
            default: ;
        endcase

        if (!legal) begin
            dec.illegal = 1'b1;
            dec.alu_op  = ALU_ADD;
            dec.op1_sel = OP1_RS1;
            dec.op2_sel = OP2_RS2;
            dec.imm     = '0;
            dec.rs2     = instr_i[24:20];
        end
        dec.rd_we = legal && (dec.rd != 5'd0);
    end

    assign dec_o = dec;

endmodule

// File: rtl/alu_issue_decode.sv
// Issue/decode stage in front of the integer ALU: decodes each fetched
// instruction and holds it in a two-entry skid buffer (main + skid).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous discard of every buffered entry
//   bus        : fetch handshake in, decoded entry handshake out (slave side)
module alu_issue_decode #(
    parameter int XLEN = alu_pkg::XLEN,
    parameter int PC_W = alu_pkg::PC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    alu_issue_decode_if.slave  bus
);

    import alu_pkg::*;

    decoded_t decIn;
    decoded_t newEntry;
    decoded_t main_q, main_d;
    decoded_t skid_q, skid_d;
    logic     mainValid_q, mainValid_d;
    logic     skidValid_q, skidValid_d;
    logic     inReady_q, inReady_d;
    logic     accept;
    logic     drain;

    alu_instr_decoder u_decoder (
        .instr_i (bus.in_instr),
        .dec_o   (decIn)
    );

    always_comb begin
        newEntry    = decIn;
        newEntry.pc = bus.in_pc;
    end

    assign accept = bus.in_valid && inReady_q;
    assign drain  = mainValid_q && bus.out_ready;

    // The skid entry only fills while main is stalled, and in_ready is low
    // whenever it is full, so a drain never coincides with an accept while
    // the skid entry is occupied.
    always_comb begin
        main_d      = main_q;
        skid_d      = skid_q;
        mainValid_d = mainValid_q;
        skidValid_d = skidValid_q;

        if (flush) begin
            mainValid_d = 1'b0;
            skidValid_d = 1'b0;
        end else if (drain) begin
            if (skidValid_q) begin
                main_d      = skid_q;
                mainValid_d = 1'b1;
                skidValid_d = 1'b0;
            end else begin
                mainValid_d = accept;
                if (accept) begin
                    main_d = newEntry;
                end
            end
        end else if (accept) begin
            if (mainValid_q) begin
                skid_d      = newEntry;
                skidValid_d = 1'b1;
            end else begin
                main_d      = newEntry;
                mainValid_d = 1'b1;
            end
        end

        inReady_d = !skidValid_d;
    end

    // Entry payloads are cleared on reset so every data output reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q      <= '0;
            skid_q      <= '0;
            mainValid_q <= 1'b0;
            skidValid_q <= 1'b0;
            inReady_q   <= 1'b1;
        end else begin
            main_q      <= main_d;
            skid_q      <= skid_d;
            mainValid_q <= mainValid_d;
            skidValid_q <= skidValid_d;
            inReady_q   <= inReady_d;
        end
    end

    assign bus.in_ready    = inReady_q;
    assign bus.out_valid   = mainValid_q;
    assign bus.out_alu_op  = main_q.alu_op;
    assign bus.out_op1_sel = main_q.op1_sel;
    assign bus.out_op2_sel = main_q.op2_sel;
    assign bus.out_imm     = main_q.imm[XLEN-1:0];
    assign bus.out_rs1     = main_q.rs1;
    assign bus.out_rs2     = main_q.rs2;
    assign bus.out_rd      = main_q.rd;
    assign bus.out_rd_we   = main_q.rd_we;
    assign bus.out_illegal = main_q.illegal;
    assign bus.out_pc      = main_q.pc[PC_W-1:0];

endmodule
